// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: widths, op codes,
// FSM states and the magnitude helper used on signed operands.
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic negate);
        return negate ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: launch, MTHI/MTLO writes,
// and the HI/LO/status returned to the hazard unit and MFHI/MFLO path.
interface ex_muldiv_unit_if;
    import mips_pkg::*;

    logic            start;
    op_e             op;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            mthi;
    logic            mtlo;
    logic [XLEN-1:0] wr_data;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, wr_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, wr_data,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit
// per step. After XLEN steps, {acc,mq} holds the product or {remainder,quotient}.
module muldiv_core
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic             last_o,
    output logic [XLEN-1:0]  acc_o,
    output logic [XLEN-1:0]  mq_o
);

    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  mq_q, mq_d;
    logic [XLEN-1:0]  b_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN:0]    add_sum;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        add_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        shifted = {acc_q, mq_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        acc_d   = acc_q;
        mq_d    = mq_q;
        if (div_q) begin
            // The partial remainder stays below the divisor, so diff[XLEN] is a clean borrow.
            if (!diff[XLEN]) begin
                acc_d = diff[XLEN-1:0];
                mq_d  = {mq_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = shifted[XLEN-1:0];
                mq_d  = {mq_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = add_sum[XLEN:1];
            mq_d  = {add_sum[0], mq_q[XLEN-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            mq_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= '0;
            mq_q  <= a_i;
            b_q   <= b_i;
            div_q <= is_div_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last_o = (cnt_q == CNT_W'(XLEN-1));
    assign acc_o  = acc_q;
    assign mq_o   = mq_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage MULT/MULTU/DIV/DIVU unit: sign handling, IDLE/RUN/FIX control and
// the architectural HI/LO registers around the unsigned muldiv_core.
module ex_muldiv_unit
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave bus
);

    state_e          state_q;
    op_e             op_q;
    logic            neg_res_q;
    logic            neg_rem_q;
    logic            dbz_q;
    logic [XLEN-1:0] rs_raw_q;
    logic [XLEN-1:0] hi_q, lo_q;
    logic            done_q;
    logic            dbz_out_q;

    logic            launch;
    logic            is_signed;
    logic            sign_a, sign_b;
    logic            core_last;
    logic [XLEN-1:0] core_acc, core_mq;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [2*XLEN-1:0] product;

    assign launch    = (state_q == ST_IDLE) && bus.start;
    assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign sign_a    = is_signed && bus.rs_data[XLEN-1];
    assign sign_b    = is_signed && bus.rt_data[XLEN-1];

    muldiv_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (launch),
        .step_i   (state_q == ST_RUN),
        .is_div_i (bus.op[1]),
        .a_i      (abs_val(bus.rs_data, sign_a)),
        .b_i      (abs_val(bus.rt_data, sign_b)),
        .last_o   (core_last),
        .acc_o    (core_acc),
        .mq_o     (core_mq)
    );

    // Signed results are applied to the unsigned core output only at FIX.
    always_comb begin
        product = {core_acc, core_mq};
        hi_d    = core_acc;
        lo_d    = core_mq;
        if (!op_q[1]) begin
            if (neg_res_q) product = -product;
            hi_d = product[2*XLEN-1:XLEN];
            lo_d = product[XLEN-1:0];
        end else if (dbz_q) begin
            hi_d = rs_raw_q;
            lo_d = '1;
        end else begin
            hi_d = neg_rem_q ? -core_acc : core_acc;
            lo_d = neg_res_q ? -core_mq  : core_mq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            rs_raw_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q      <= bus.op;
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        dbz_q     <= bus.op[1] && (bus.rt_data == '0);
                        rs_raw_q  <= bus.rs_data;
                        state_q   <= ST_RUN;
                    end else begin
                        if (bus.mthi) hi_q <= bus.wr_data;
                        if (bus.mtlo) lo_q <= bus.wr_data;
                    end
                end
                ST_RUN: begin
                    if (core_last) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q      <= hi_d;
                    lo_q      <= lo_d;
                    done_q    <= 1'b1;
                    dbz_out_q <= dbz_q;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO/flag pushed at launch,
// popped and compared when done pulses; latency and control cases checked inline.
module tb_ex_muldiv_unit;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    ex_muldiv_unit_if bus ();

    ex_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb_l, q, r;
        logic [63:0] p;
        e.dbz = 1'b0;
        sa    = longint'($signed(a));
        sb_l  = longint'($signed(b));
        case (op)
            OP_MULT:  begin p = 64'(sa * sb_l); e.hi = p[63:32]; e.lo = p[31:0]; end
            OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    q = sa / sb_l; r = sa % sb_l;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic launch_mthi, input logic inject_mid, input string name);
        int   n;
        logic early_done;
        exp_t e;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.mthi    = launch_mthi;
        bus.wr_data = 32'h5555_AAAA;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        vectors++;
        if (bus.hi !== exp_hi) begin
            errors++;
            $display("FAIL %s hi_held: got %h want %h", name, bus.hi, exp_hi);
        end
        n = 0;
        early_done = 1'b0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (bus.done !== 1'b0) early_done = 1'b1;
            if (inject_mid && n == 10) begin
                bus.start = 1'b1; bus.op = OP_MULTU; bus.mthi = 1'b1; bus.mtlo = 1'b1;
                bus.rs_data = 32'h0000_0003; bus.rt_data = 32'h0000_0005;
            end else begin
                bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        vectors++;
        if (n !== 33 || early_done) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d (early_done=%0b) want 33", name, n, early_done);
        end
        vectors++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b want 1", name, bus.done);
        end
        e = sb.pop_front();
        vectors++;
        if (bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                     name, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
        end
        exp_hi = e.hi;
        exp_lo = e.lo;
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL %s after_done: got done=%b dbz=%b hi=%h lo=%h want 0 0 %h %h",
                     name, bus.done, bus.div_by_zero, bus.hi, bus.lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = OP_MULT; bus.rs_data = '0; bus.rt_data = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wr_data = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
            bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h want all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0, "mult_neg3x7");
        vectors++;
        if (exp_hi !== 32'hFFFF_FFFF || exp_lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_model: got hi=%h lo=%h want ffffffff ffffffeb", exp_hi, exp_lo);
        end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, "multu_max_ignore_start");
    endtask

    task automatic test_div();
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, "div_neg7_2");
        run_op(OP_DIVU, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, "divu_7_2");
        run_op(OP_DIV,  32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, "div_by_zero");
        run_op(OP_DIVU, 32'hCAFE_0001, 32'h0000_0000, 1'b0, 1'b0, "divu_by_zero");
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_overflow");
    endtask

    task automatic test_mthi_mtlo();
        bus.mthi = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mthi = 1'b0;
        exp_hi = 32'hDEAD_BEEF;
        vectors++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL mthi: got hi=%h lo=%h want %h %h", bus.hi, bus.lo, exp_hi, exp_lo);
        end
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wr_data = 32'h0BAD_F00D;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        exp_hi = 32'h0BAD_F00D;
        exp_lo = 32'h0BAD_F00D;
        vectors++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h want %h %h", bus.hi, bus.lo, exp_hi, exp_lo);
        end
        run_op(OP_MULTU, 32'h0001_0000, 32'h0003_0000, 1'b1, 1'b0, "start_beats_mthi");
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        bus.start = 1'b1; bus.op = OP_MULT; bus.rs_data = 32'h1234_5678; bus.rt_data = 32'h0000_0100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
        end
        vectors++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles want 0", seen_done);
        end
        run_op(OP_MULTU, 32'd5, 32'd6, 1'b0, 1'b0, "multu_after_reset");
    endtask

    task automatic test_back_to_back();
        op_e         op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = op_e'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if (i == 0) b = 32'h8000_0000;
            run_op(op, a, b, 1'b0, 1'b0, $sformatf("b2b_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_reset_mid_run();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
